vector_load_collector: RTL and testbench

Upstream feeder of the vector register file for unit-stride vector loads. Accepts one load command (base address, vector length, element width, destination register, mask), fetches the covered 32-bit memory words one request at a time, and packs them into a full-vector buffer using the register file's tight little-endian element layout. It then issues exactly one masked write-back to the vector register file.

---
 rtl/vector_load_collector_pkg.sv | 31 +++
 rtl/vector_load_collector_size_calc.sv | 36 +++
 rtl/vector_load_collector.sv | 140 ++++++++++++++
 tb/tb_vector_load_collector.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_load_collector_pkg.sv
// Shared codes and helpers for the unit-stride vector load collector.
package vector_load_collector_pkg;

  localparam logic [2:0] ONE_BYTE   = 3'd0;
  localparam logic [2:0] TWO_BYTE   = 3'd1;
  localparam logic [2:0] FOUR_BYTE  = 3'd2;
  localparam logic [2:0] EIGHT_BYTE = 3'd3;

  localparam logic [1:0] RF_NOP          = 2'd0;
  localparam logic [1:0] VECTOR_RF_WRITE = 2'd1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // log2 of the element size in bytes
  function automatic logic [1:0] elem_bytes_log2(input logic [2:0] data_type);
    case (data_type)
      ONE_BYTE:   elem_bytes_log2 = 2'd0;
      TWO_BYTE:   elem_bytes_log2 = 2'd1;
      FOUR_BYTE:  elem_bytes_log2 = 2'd2;
      EIGHT_BYTE: elem_bytes_log2 = 2'd3;
      default:    elem_bytes_log2 = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/vector_load_collector_size_calc.sv
// Converts a load command's element count and width into fetch words, clamped length and overflow.
module vlc_size_calc
  import vector_load_collector_pkg::*;
#(
  parameter int DATA_LEN         = 32,
  parameter int BYTE_SIZE        = 8,
  parameter int VECTOR_SIZE      = 8,
  parameter int ENTRY_INDEX_SIZE = 3
) (
  input  logic [2:0]                data_type,
  input  logic [DATA_LEN-1:0]       length,
  output logic [ENTRY_INDEX_SIZE:0] words,
  output logic [DATA_LEN-1:0]       clamped_length,
  output logic                      overflow
);

  localparam int WB        = $clog2(DATA_LEN / BYTE_SIZE);
  localparam int BUF_BYTES = VECTOR_SIZE * (DATA_LEN / BYTE_SIZE);

  logic [1:0]                   shift;
  logic [DATA_LEN+2:0]          bytes;
  logic [ENTRY_INDEX_SIZE+WB:0] bytes_lo;
  logic [ENTRY_INDEX_SIZE:0]    words_raw;

  assign shift    = elem_bytes_log2(data_type);
  assign bytes    = {3'b000, length} << shift;
  assign overflow = bytes > (DATA_LEN+3)'(BUF_BYTES);

  // Only the low bits matter once overflow is ruled out; partial words round up.
  assign bytes_lo  = bytes[ENTRY_INDEX_SIZE+WB:0];
  assign words_raw = bytes_lo[ENTRY_INDEX_SIZE+WB:WB] + (ENTRY_INDEX_SIZE+1)'(|bytes_lo[WB-1:0]);

  assign words          = overflow ? (ENTRY_INDEX_SIZE+1)'(VECTOR_SIZE) : words_raw;
  assign clamped_length = overflow ? DATA_LEN'(BUF_BYTES >> shift) : length;

endmodule

// File: rtl/vector_load_collector.sv
// Fetches the words of one unit-stride vector load and issues a single masked register-file write.
module vector_load_collector
  import vector_load_collector_pkg::*;
#(
  parameter int ADDR_WIDTH       = 17,
  parameter int DATA_LEN         = 32,
  parameter int BYTE_SIZE        = 8,
  parameter int VECTOR_SIZE      = 8,
  parameter int ENTRY_INDEX_SIZE = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rdy_in,
  input  logic                            start,
  input  logic [ADDR_WIDTH-1:0]           base_addr,
  input  logic [DATA_LEN-1:0]             length,
  input  logic [2:0]                      data_type,
  input  logic [4:0]                      rd,
  input  logic                            vm,
  input  logic [VECTOR_SIZE*DATA_LEN-1:0] mask,
  output logic                            mem_req,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  input  logic                            mem_rsp_valid,
  input  logic [DATA_LEN-1:0]             mem_rsp_data,
  output logic [1:0]                      rf_signal,
  output logic [4:0]                      rf_rd,
  output logic                            rf_vm,
  output logic [VECTOR_SIZE*DATA_LEN-1:0] rf_mask,
  output logic [DATA_LEN-1:0]             rf_length,
  output logic [2:0]                      rf_data_type,
  output logic [VECTOR_SIZE*DATA_LEN-1:0] rf_data,
  output logic                            write_back_enabled,
  output logic                            busy,
  output logic                            done,
  output logic                            err,
  output logic [2:0]                      fsm_state
);

  // Memory handshake: mem_req is a one-cycle request with at most one outstanding;
  // the matching word is accepted only in WAIT on a cycle where mem_rsp_valid and rdy_in are high.
  localparam int WB = $clog2(DATA_LEN / BYTE_SIZE);
  localparam logic [ENTRY_INDEX_SIZE:0] K_ONE = (ENTRY_INDEX_SIZE+1)'(1);

  state_t                            state_q, state_d;
  logic [ENTRY_INDEX_SIZE:0]         k_q, words_q;
  logic [ADDR_WIDTH-1:0]             base_q;
  logic [VECTOR_SIZE*DATA_LEN-1:0]   buf_q, mask_q;
  logic [DATA_LEN-1:0]               len_q;
  logic [4:0]                        rd_q;
  logic [2:0]                        dtype_q;
  logic                              vm_q, err_q;

  logic [ENTRY_INDEX_SIZE:0] words;
  logic [DATA_LEN-1:0]       clamped_length;
  logic                      overflow, misaligned;

  vlc_size_calc #(
    .DATA_LEN        (DATA_LEN),
    .BYTE_SIZE       (BYTE_SIZE),
    .VECTOR_SIZE     (VECTOR_SIZE),
    .ENTRY_INDEX_SIZE(ENTRY_INDEX_SIZE)
  ) u_size_calc (
    .data_type     (data_type),
    .length        (length),
    .words         (words),
    .clamped_length(clamped_length),
    .overflow      (overflow)
  );

  assign misaligned = |base_addr[WB-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        state_q <= S_IDLE;
    else if (rdy_in) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (length == '0 || misaligned) ? S_DONE : S_REQ;
      S_REQ:   state_d = S_WAIT;
      S_WAIT:  if (mem_rsp_valid) state_d = (k_q + K_ONE == words_q) ? S_WRITE : S_REQ;
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q  <= '0;
      rd_q    <= '0;
      vm_q    <= 1'b0;
      mask_q  <= '0;
      dtype_q <= '0;
      len_q   <= '0;
      words_q <= '0;
      err_q   <= 1'b0;
      buf_q   <= '0;
      k_q     <= '0;
    end else if (rdy_in) begin
      case (state_q)
        S_IDLE: if (start) begin
          base_q  <= base_addr;
          rd_q    <= rd;
          vm_q    <= vm;
          mask_q  <= mask;
          dtype_q <= data_type;
          len_q   <= clamped_length;
          words_q <= words;
          err_q   <= misaligned | overflow;
          buf_q   <= '0;
          k_q     <= '0;
        end
        // Word k lands in slot k, giving the little-endian element packing directly.
        S_WAIT: if (mem_rsp_valid) begin
          buf_q[k_q[ENTRY_INDEX_SIZE-1:0]*DATA_LEN +: DATA_LEN] <= mem_rsp_data;
          k_q <= k_q + K_ONE;
        end
        default: ;
      endcase
    end
  end

  assign mem_req            = (state_q == S_REQ);
  assign mem_addr           = mem_req ? base_q + (ADDR_WIDTH'(k_q) << WB) : '0;
  assign write_back_enabled = (state_q == S_WRITE);
  assign rf_signal          = write_back_enabled ? VECTOR_RF_WRITE : RF_NOP;
  assign busy               = (state_q != S_IDLE);
  assign done               = (state_q == S_DONE);
  assign err                = err_q;
  assign rf_rd              = rd_q;
  assign rf_vm              = vm_q;
  assign rf_mask            = mask_q;
  assign rf_length          = len_q;
  assign rf_data_type       = dtype_q;
  assign rf_data            = buf_q;
  assign fsm_state          = state_q;

endmodule

// File: tb/tb_vector_load_collector.sv
// Directed and randomized load commands against a latency-configurable memory model with a scoreboard.
module tb_vector_load_collector;
  import vector_load_collector_pkg::*;

  logic         clk = 1'b0;
  logic         rst, rdy_in, start;
  logic [16:0]  base_addr;
  logic [31:0]  length;
  logic [2:0]   data_type;
  logic [4:0]   rd;
  logic         vm;
  logic [255:0] mask;
  logic         mem_req;
  logic [16:0]  mem_addr;
  logic         mem_rsp_valid;
  logic [31:0]  mem_rsp_data;
  logic [1:0]   rf_signal;
  logic [4:0]   rf_rd;
  logic         rf_vm;
  logic [255:0] rf_mask;
  logic [31:0]  rf_length;
  logic [2:0]   rf_data_type;
  logic [255:0] rf_data;
  logic         write_back_enabled, busy, done, err;
  logic [2:0]   fsm_state;

  logic         mem_valid_r, spurious;
  assign mem_rsp_valid = mem_valid_r | spurious;

  int           vectors_applied = 0;
  int           miscompares = 0;
  int           lat = 1;
  int           req_count = 0;
  int           cnt = 0;
  logic [31:0]  seed = '0;
  logic [16:0]  cur_base = '0;
  logic [255:0] exp_q[$];
  logic [16:0]  addr_q[$];

  always #5 clk = ~clk;

  vector_load_collector dut (
    .clk(clk), .rst(rst), .rdy_in(rdy_in), .start(start), .base_addr(base_addr),
    .length(length), .data_type(data_type), .rd(rd), .vm(vm), .mask(mask),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .rf_signal(rf_signal), .rf_rd(rf_rd), .rf_vm(rf_vm),
    .rf_mask(rf_mask), .rf_length(rf_length), .rf_data_type(rf_data_type),
    .rf_data(rf_data), .write_back_enabled(write_back_enabled), .busy(busy),
    .done(done), .err(err), .fsm_state(fsm_state)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors_applied++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory model: samples just before each rising edge, answers lat cycles after a request,
  // and holds a response until it is seen with rdy_in high.
  initial begin
    logic        s_req, s_rdy, s_valid;
    logic [16:0] s_addr;
    logic [31:0] pend;
    mem_valid_r  = 1'b0;
    mem_rsp_data = '0;
    pend         = '0;
    forever begin
      @(negedge clk);
      #4;
      s_req = mem_req; s_addr = mem_addr; s_rdy = rdy_in; s_valid = mem_rsp_valid;
      @(posedge clk);
      #1;
      if (s_valid && s_rdy) mem_valid_r = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin mem_valid_r = 1'b1; mem_rsp_data = pend; end
      end
      if (s_req && s_rdy) begin
        req_count++;
        if (addr_q.size() == 0) check("req_unexpected", 256'(s_req), 256'(0));
        else check("mem_addr", 256'(s_addr), 256'(addr_q.pop_front()));
        pend = seed + 32'((s_addr - cur_base) >> 2);
        if (lat <= 1) begin mem_valid_r = 1'b1; mem_rsp_data = pend; end
        else cnt = lat - 1;
      end
    end
  end

  task automatic run_cmd(input logic [16:0] b, input logic [31:0] len, input logic [2:0] dt,
                         input logic [4:0] rdv, input logic vmv, input logic [255:0] mv,
                         input logic [31:0] sd, input int stall_at, input bit poke);
    int          sh, words, w_cyc, d_cyc;
    longint      bytes;
    bit          over, mis, wr, err_e, seen_w, seen_d;
    logic [31:0] clamp;
    logic [255:0] exp_data;
    case (dt)
      ONE_BYTE:  sh = 0;
      TWO_BYTE:  sh = 1;
      FOUR_BYTE: sh = 2;
      default:   sh = 3;
    endcase
    bytes = longint'(len) << sh;
    over  = bytes > 32;
    words = over ? 8 : int'((bytes + 3) / 4);
    clamp = over ? 32'(32 >> sh) : len;
    mis   = b[1:0] != 2'b00;
    err_e = mis | over;
    wr    = !mis && len != 0;
    exp_data = '0;
    if (wr) begin
      for (int k = 0; k < words; k++) begin
        addr_q.push_back(17'(b + 17'(4 * k)));
        exp_data[k*32 +: 32] = sd + 32'(k);
      end
      exp_q.push_back(exp_data);
    end
    w_cyc = 1 + words * (1 + lat) + (stall_at > 0 ? 3 : 0);
    d_cyc = wr ? w_cyc + 1 : 1;

    @(negedge clk);
    cur_base = b; seed = sd; req_count = 0;
    start = 1'b1; base_addr = b; length = len; data_type = dt; rd = rdv; vm = vmv; mask = mv;
    @(posedge clk);
    #1;
    start = 1'b0;
    base_addr = 17'($urandom); length = $urandom; data_type = 3'($urandom_range(0, 3));
    rd = ~rdv; vm = ~vmv; mask = ~mv;

    seen_w = 0; seen_d = 0;
    for (int n = 1; n <= 300 && !seen_d; n++) begin
      @(negedge clk);
      if (write_back_enabled) begin
        seen_w = 1;
        check("wb_cycle", 256'(n), 256'(w_cyc));
        if (exp_q.size() > 0) check("rf_data", rf_data, exp_q.pop_front());
        else check("wb_unexpected", 256'(write_back_enabled), 256'(0));
        check("rf_signal", 256'(rf_signal), 256'(VECTOR_RF_WRITE));
        check("rf_length", 256'(rf_length), 256'(clamp));
        check("rf_rd", 256'(rf_rd), 256'(rdv));
        check("rf_vm", 256'(rf_vm), 256'(vmv));
        check("rf_mask", rf_mask, mv);
        check("rf_data_type", 256'(rf_data_type), 256'(dt));
      end else begin
        check("rf_signal_nop", 256'(rf_signal), 256'(RF_NOP));
      end
      if (done) begin
        seen_d = 1;
        check("done_cycle", 256'(n), 256'(d_cyc));
        check("err", 256'(err), 256'(err_e));
      end
      if (poke && n == 3) start = 1'b1;
      if (poke && n == 4) start = 1'b0;
      if (stall_at > 0 && n == stall_at) rdy_in = 1'b0;
      if (stall_at > 0 && n == stall_at + 3) rdy_in = 1'b1;
    end
    check("done_seen", 256'(seen_d), 256'(1));
    check("wb_seen", 256'(seen_w), 256'(wr));
    check("req_count", 256'(req_count), 256'(wr ? words : 0));
    @(negedge clk);
    check("done_pulse", 256'(done), 256'(0));
    check("busy_idle", 256'(busy), 256'(0));
    check("err_held", 256'(err), 256'(err_e));
    check("addr_q_empty", 256'(addr_q.size()), 256'(0));
    check("exp_q_empty", 256'(exp_q.size()), 256'(0));
    addr_q.delete();
    exp_q.delete();
  endtask

  function automatic logic [255:0] rand_mask();
    logic [255:0] m;
    for (int i = 0; i < 8; i++) m[i*32 +: 32] = $urandom;
    return m;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; rdy_in = 1'b1; start = 1'b0; spurious = 1'b0;
    base_addr = '0; length = '0; data_type = '0; rd = '0; vm = 1'b1; mask = '0;

    @(negedge clk);
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_state", 256'(fsm_state), 256'(S_IDLE));
    check("rst_mem_req", 256'(mem_req), 256'(0));
    check("rst_rf_data", rf_data, 256'(0));
    check("rst_err", 256'(err), 256'(0));
    check("rst_done", 256'(done), 256'(0));
    @(negedge clk);
    rst = 1'b1;

    lat = 1;
    run_cmd(17'h100, 32'd3, FOUR_BYTE, 5'd7, 1'b1, '0, 32'hCAFE_0000, 0, 1'b1);
    lat = 2;
    run_cmd(17'h040, 32'd4, EIGHT_BYTE, 5'd12, 1'b0, rand_mask(), 32'h1111_0000, 0, 1'b0);
    lat = 1;
    run_cmd(17'h080, 32'd0, ONE_BYTE, 5'd3, 1'b1, '0, 32'h0, 0, 1'b0);
    run_cmd(17'h200, 32'd12, FOUR_BYTE, 5'd31, 1'b1, rand_mask(), 32'hBEEF_0100, 0, 1'b0);
    run_cmd(17'h102, 32'd2, FOUR_BYTE, 5'd1, 1'b1, '0, 32'h0, 0, 1'b0);
    run_cmd(17'h180, 32'd3, FOUR_BYTE, 5'd9, 1'b1, '0, 32'h5A5A_0000, 2, 1'b0);
    lat = 3;
    run_cmd(17'h020, 32'd5, ONE_BYTE, 5'd4, 1'b0, rand_mask(), 32'h0102_0304, 0, 1'b0);
    lat = 1;
    run_cmd(17'h1FF00, 32'd7, TWO_BYTE, 5'd18, 1'b1, '0, 32'h7700_0000, 0, 1'b0);
    run_cmd(17'h000, 32'd40, EIGHT_BYTE, 5'd22, 1'b1, '0, 32'hD000_0000, 0, 1'b0);

    for (int t = 0; t < 5; t++) begin
      lat = $urandom_range(1, 3);
      run_cmd(17'({$urandom_range(0, 16'h7FFF), 2'b00}), 32'($urandom_range(0, 20)),
              3'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
              rand_mask(), $urandom, 0, 1'b0);
    end

    // Reset during the third WAIT, then a stray response strobe.
    lat = 1;
    @(negedge clk);
    cur_base = 17'h300; seed = 32'h3300_0000; req_count = 0;
    for (int k = 0; k < 3; k++) addr_q.push_back(17'(17'h300 + 17'(4 * k)));
    start = 1'b1; base_addr = 17'h300; length = 32'd4; data_type = FOUR_BYTE; rd = 5'd6;
    vm = 1'b1; mask = '1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int n = 1; n <= 6; n++) @(negedge clk);
    check("pre_rst_state", 256'(fsm_state), 256'(S_WAIT));
    rst = 1'b0;
    #1;
    check("mid_rst_busy", 256'(busy), 256'(0));
    check("mid_rst_state", 256'(fsm_state), 256'(S_IDLE));
    check("mid_rst_wb", 256'(write_back_enabled), 256'(0));
    check("mid_rst_rf_data", rf_data, 256'(0));
    check("mid_rst_rf_length", 256'(rf_length), 256'(0));
    check("mid_rst_rf_mask", rf_mask, 256'(0));
    check("mid_rst_rf_rd", 256'(rf_rd), 256'(0));
    @(negedge clk);
    rst = 1'b1;
    spurious = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("spur_wb", 256'(write_back_enabled), 256'(0));
      check("spur_state", 256'(fsm_state), 256'(S_IDLE));
      check("spur_rf_data", rf_data, 256'(0));
      check("spur_done", 256'(done), 256'(0));
    end
    spurious = 1'b0;
    check("rst_req_count", 256'(req_count), 256'(3));
    check("rst_addr_q_empty", 256'(addr_q.size()), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
